fetch_stage: RTL and testbench

//  Instruction-fetch stage of the LC-3b pipeline, directly upstream of the IF/ID register.
//  - Owns the PC and runs the read/resp handshake with the instruction cache.
//  - Presents the packed word {pc+2, instr} to the IF/ID register.
//  - Handles downstream stalls, and redirects from branch/JMP/JSR/TRAP.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-cache read/resp handshake between the fetch stage (master) and the icache (slave).
interface fetch_stage_if;
    logic        icache_read;
    logic [15:0] icache_address;
    logic [15:0] icache_rdata;
    logic        icache_resp;

    modport master (
        output icache_read,
        output icache_address,
        input  icache_rdata,
        input  icache_resp
    );

    modport slave (
        input  icache_read,
        input  icache_address,
        output icache_rdata,
        output icache_resp
    );
endinterface

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, runs the icache handshake, feeds IF/ID.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_in,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    fetch_stage_if.master        icache,
    output logic [31:0]          ifid_in,
    output logic                 ifid_load,
    output logic                 ifid_squash,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt,
    output logic [15:0]          perf_redir_cnt
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] tgt, tgt_n;
    logic [31:0] hold_word, hold_word_n;
    logic [15:0] next_pc;

    assign next_pc              = pc + 16'd2;
    assign icache.icache_address = pc;
    assign ifid_load            = ~stall_in;
    assign ifid_squash          = redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            tgt       <= RESET_PC;
            hold_word <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            tgt       <= tgt_n;
            hold_word <= hold_word_n;
        end
    end

    always_comb begin
        state_n            = state;
        pc_n               = pc;
        tgt_n              = tgt;
        hold_word_n        = hold_word;
        icache.icache_read = 1'b0;
        ifid_in            = '0;
        case (state)
            FETCH: begin
                icache.icache_read = 1'b1;
                if (icache.icache_resp) begin
                    if (redirect) begin
                        pc_n = redirect_pc;
                    end else begin
                        pc_n = next_pc;
                        if (stall_in) begin
                            hold_word_n = {next_pc, icache.icache_rdata};
                            state_n     = HOLD;
                        end else begin
                            ifid_in = {next_pc, icache.icache_rdata};
                        end
                    end
                end else if (redirect) begin
                    tgt_n   = redirect_pc;
                    state_n = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n        = redirect_pc;
                    hold_word_n = '0;
                    state_n     = FETCH;
                end else if (!stall_in) begin
                    ifid_in = hold_word;
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                // Address stays on the old pc until the in-flight read completes; newest target wins.
                icache.icache_read = 1'b1;
                if (icache.icache_resp) begin
                    pc_n    = redirect ? redirect_pc : tgt;
                    state_n = FETCH;
                end else if (redirect) begin
                    tgt_n = redirect_pc;
                end
            end
            default: state_n = FETCH;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic deliver;

    assign deliver = !redirect && !stall_in &&
                     ((state == FETCH && icache.icache_resp) || state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_redir_cnt <= '0;
        end else begin
            if (deliver)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_in) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect) perf_redir_cnt <= perf_redir_cnt + 16'd1;
        end
    end
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
    assign perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [31:0] ifid_in;
    logic        ifid_load;
    logic        ifid_squash;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_redir_cnt;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .icache         (bus.master),
        .ifid_in        (ifid_in),
        .ifid_load      (ifid_load),
        .ifid_squash    (ifid_squash),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_redir_cnt (perf_redir_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: current pc, a word parked for a stalled consumer, and a pending redirect target
    logic [15:0] m_pc;
    logic [31:0] held[$];
    logic [15:0] target[$];
    logic [31:0] m_fetch, m_stall;
    logic [15:0] m_redir;

    logic [31:0] seen_ifid;
    logic        seen_load, seen_squash;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000;
        held.delete();
        target.delete();
        m_fetch = '0;
        m_stall = '0;
        m_redir = '0;
    endtask

    task automatic step(input logic st, input logic rd, input logic [15:0] rpc,
                        input logic rs, input logic [15:0] rdat, input logic rst);
        logic        reading;
        logic        deliver;
        logic [31:0] exp_word;
        @(negedge clk);
        reading            = (held.size() == 0);
        stall_in           = st;
        redirect           = rd;
        redirect_pc        = rpc;
        bus.icache_resp    = rs && reading;
        bus.icache_rdata   = rdat;
        reset              = rst;
        #1;
        deliver  = 1'b0;
        exp_word = '0;
        if (held.size() != 0) begin
            if (!st && !rd) begin
                deliver  = 1'b1;
                exp_word = held[0];
            end
        end else if (bus.icache_resp && !rd && !st && target.size() == 0) begin
            deliver  = 1'b1;
            exp_word = {m_pc + 16'd2, rdat};
        end
        check("icache_read", {31'b0, bus.icache_read}, {31'b0, reading});
        if (reading) check("icache_address", {16'b0, bus.icache_address}, {16'b0, m_pc});
        check("ifid_in", ifid_in, exp_word);
        check("ifid_load", {31'b0, ifid_load}, {31'b0, ~st});
        check("ifid_squash", {31'b0, ifid_squash}, {31'b0, rd});
        check("perf_fetch", perf_fetch_cnt, PERF ? m_fetch : 32'd0);
        check("perf_stall", perf_stall_cnt, PERF ? m_stall : 32'd0);
        check("perf_redir", {16'b0, perf_redir_cnt}, PERF ? {16'b0, m_redir} : 32'd0);
        seen_ifid   = ifid_in;
        seen_load   = ifid_load;
        seen_squash = ifid_squash;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (deliver) m_fetch = m_fetch + 32'd1;
            if (st)      m_stall = m_stall + 32'd1;
            if (rd)      m_redir = m_redir + 16'd1;
            if (held.size() != 0) begin
                if (rd) begin
                    held.delete();
                    m_pc = rpc;
                end else if (!st) begin
                    held.delete();
                end
            end else if (target.size() != 0) begin
                if (bus.icache_resp) begin
                    m_pc = rd ? rpc : target[0];
                    target.delete();
                end else if (rd) begin
                    target[0] = rpc;
                end
            end else if (bus.icache_resp) begin
                if (rd) begin
                    m_pc = rpc;
                end else begin
                    if (st) held.push_back({m_pc + 16'd2, rdat});
                    m_pc = m_pc + 16'd2;
                end
            end else if (rd) begin
                target.push_back(rpc);
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        stall_in         = 1'b0;
        redirect         = 1'b0;
        redirect_pc      = '0;
        bus.icache_resp  = 1'b0;
        bus.icache_rdata = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Test 1: plain delivery at reset pc
        step(0, 0, 16'h0, 1, 16'h1234, 0);
        check("t1_ifid", seen_ifid, 32'h0002_1234);
        check("t1_load", {31'b0, seen_load}, 32'd1);
        #1 check("t1_next_addr", {16'b0, bus.icache_address}, 32'h0000_0002);

        // Test 2: stalled resp parks the word, delivered once on release
        step(1, 0, 16'h0, 1, 16'h5678, 0);
        step(1, 0, 16'h0, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0, 16'h0, 0);
        #1 check("t2_hold_read", {31'b0, bus.icache_read}, 32'd0);
        step(0, 0, 16'h0, 0, 16'h0, 0);
        check("t2_release", seen_ifid, 32'h0004_5678);
        #1 check("t2_next_addr", {16'b0, bus.icache_address}, 32'h0000_0004);

        // Test 3: redirect while read pending drains the old read
        step(0, 1, 16'h3000, 0, 16'h0, 0);
        check("t3_squash", {31'b0, seen_squash}, 32'd1);
        #1 check("t3_addr_held", {16'b0, bus.icache_address}, 32'h0000_0004);
        step(0, 0, 16'h0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 1, 16'hDEAD, 0);
        check("t3_stale", seen_ifid, 32'h0);
        #1 check("t3_next_addr", {16'b0, bus.icache_address}, 32'h0000_3000);

        // Test 4: resp and redirect together
        step(0, 1, 16'h4000, 1, 16'hBEEF, 0);
        check("t4_dropped", seen_ifid, 32'h0);
        #1 check("t4_next_addr", {16'b0, bus.icache_address}, 32'h0000_4000);

        // Test 5: pc wrap at 0xFFFE
        step(0, 1, 16'hFFFE, 0, 16'h0, 0);
        step(0, 0, 16'h0, 1, 16'h1111, 0);
        step(0, 0, 16'h0, 1, 16'hABCD, 0);
        check("t5_wrap_word", seen_ifid, 32'h0000_ABCD);
        #1 check("t5_next_addr", {16'b0, bus.icache_address}, 32'h0);

        // Test 6: reset in DRAIN
        step(1, 1, 16'h1234, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0, 16'h0, 1);
        #1;
        check("t6_addr", {16'b0, bus.icache_address}, 32'h0);
        check("t6_read", {31'b0, bus.icache_read}, 32'd1);
        check("t6_fetch_cnt", perf_fetch_cnt, 32'd0);
        check("t6_stall_cnt", perf_stall_cnt, 32'd0);
        check("t6_redir_cnt", {16'b0, perf_redir_cnt}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3) == 0,
                 $urandom_range(7) == 0,
                 16'($urandom) & 16'hFFFE,
                 $urandom_range(1) == 1,
                 16'($urandom),
                 $urandom_range(99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
